// File: rtl/driver_cell_retimer.sv
// ============================================================================
// Module   : driver_cell_retimer
// Brief    : Retimes DAC binary/thermometer control words, regenerates the
//            complement rails, sequences power-up and flags sticky faults.
// Revision : 1.0
// ============================================================================
`default_nettype none

module driver_cell_retimer #(
  parameter int BIN_W      = 7,
  parameter int THERM_W    = 17,
  parameter int PIPE_DEPTH = 2,
  parameter int SETTLE_CYC = 8,
  parameter int BUBBLE_FIX = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pdb,
  input  logic               supply_ok,
  input  logic [BIN_W-1:0]   datain,
  input  logic [BIN_W-1:0]   datainb,
  input  logic [THERM_W-1:0] datatherm,
  input  logic [THERM_W-1:0] datathermb,
  input  logic               err_clr,
  output logic [BIN_W-1:0]   databinout,
  output logic [BIN_W-1:0]   databinoutb,
  output logic [THERM_W-1:0] datathermout,
  output logic [THERM_W-1:0] datathermoutb,
  output logic               out_en,
  output logic [1:0]         state,
  output logic               comp_err,
  output logic               therm_err,
  output logic               supply_fault
);

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int POP_W = $clog2(THERM_W + 1);

  typedef enum logic [1:0] {
    S_OFF    = 2'd0,
    S_SETTLE = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [BIN_W-1:0]   r_bin_out;
  logic [THERM_W-1:0] r_th_out;
  logic               r_oe;
  logic               r_comp_err;
  logic               r_therm_err;
  logic               r_supply_fault;

  logic               w_good;
  logic               w_active;
  logic [POP_W-1:0]   w_pop;
  logic [THERM_W-1:0] w_th_fix;
  logic [THERM_W-1:0] w_th_s0;
  logic [BIN_W-1:0]   w_bin_tail;
  logic [THERM_W-1:0] w_th_tail;
  logic               w_comp_bad;
  logic               w_therm_bad;

  assign w_good   = pdb & supply_ok;
  assign w_active = (r_state == S_ACTIVE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_OFF;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_OFF: begin
          if (w_good) begin
            r_state <= S_SETTLE;
            r_cnt   <= '0;
          end
        end
        S_SETTLE: begin
          if (!w_good) begin
            r_state <= S_OFF;
          end else if (r_cnt == CNT_W'(SETTLE_CYC - 1)) begin
            r_state <= S_ACTIVE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_ACTIVE: begin
          if (!w_good) r_state <= S_OFF;
        end
        default: r_state <= S_OFF;
      endcase
    end
  end

  // Bubble fix rebuilds a clean code holding the same number of ones.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < THERM_W; i++) w_pop = w_pop + POP_W'(datatherm[i]);
    for (int i = 0; i < THERM_W; i++) w_th_fix[i] = (i < int'(w_pop));
  end

  generate
    if (BUBBLE_FIX != 0) begin : g_bfix
      assign w_th_s0 = w_th_fix;
    end else begin : g_nobfix
      assign w_th_s0 = datatherm;
    end
  endgenerate

  generate
    if (PIPE_DEPTH > 1) begin : g_pipe
      logic [BIN_W-1:0]   r_bin_pipe [1:PIPE_DEPTH-1];
      logic [THERM_W-1:0] r_th_pipe  [1:PIPE_DEPTH-1];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 1; i < PIPE_DEPTH; i++) begin
            r_bin_pipe[i] <= '0;
            r_th_pipe[i]  <= '0;
          end
        end else begin
          r_bin_pipe[1] <= datain;
          r_th_pipe[1]  <= w_th_s0;
          for (int i = 2; i < PIPE_DEPTH; i++) begin
            r_bin_pipe[i] <= r_bin_pipe[i-1];
            r_th_pipe[i]  <= r_th_pipe[i-1];
          end
        end
      end
      assign w_bin_tail = r_bin_pipe[PIPE_DEPTH-1];
      assign w_th_tail  = r_th_pipe[PIPE_DEPTH-1];
    end else begin : g_nopipe
      assign w_bin_tail = datain;
      assign w_th_tail  = w_th_s0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin_out <= '0;
      r_th_out  <= '0;
      r_oe      <= 1'b0;
    end else begin
      r_bin_out <= w_active ? w_bin_tail : '0;
      r_th_out  <= w_active ? w_th_tail  : '0;
      r_oe      <= w_active;
    end
  end

  // A legal code plus one has no bit in common with the code itself.
  assign w_therm_bad = ((datatherm & (datatherm + THERM_W'(1))) != '0);
  assign w_comp_bad  = (|(~(datain ^ datainb))) | (|(~(datatherm ^ datathermb)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_comp_err     <= 1'b0;
      r_therm_err    <= 1'b0;
      r_supply_fault <= 1'b0;
    end else begin
      r_comp_err     <= (w_active & w_comp_bad)  | (r_comp_err     & ~err_clr);
      r_therm_err    <= (w_active & w_therm_bad) | (r_therm_err    & ~err_clr);
      r_supply_fault <= (w_active & ~supply_ok)  | (r_supply_fault & ~err_clr);
    end
  end

  assign databinout    = r_bin_out;
  assign datathermout  = r_th_out;
  assign databinoutb   = r_oe ? ~r_bin_out : '0;
  assign datathermoutb = r_oe ? ~r_th_out  : '0;
  assign out_en        = r_oe;
  assign state         = r_state;
  assign comp_err      = r_comp_err;
  assign therm_err     = r_therm_err;
  assign supply_fault  = r_supply_fault;

endmodule

`default_nettype wire

// File: doc/driver_cell_retimer.md
# driver_cell_retimer

Clocked, parametrised successor of the DAC current-switch driver cell. It sits between the segmented data path and the current-switch array. It retimes binary and thermometer control words through a configurable pipeline and regenerates the complementary rails from the true rail. A power-up settle sequencer gates the switches, and sticky flags report complement, thermometer-bubble and supply faults.

## Interface
Parameters:
- BIN_W, 7, binary LSB segment width
- THERM_W, 17, thermometer MSB segment width
- PIPE_DEPTH, 2, input-to-output latency in cycles, legal range 1..4
- SETTLE_CYC, 8, ACTIVE is entered after this many consecutive good cycles in SETTLE, legal range ≥1
- BUBBLE_FIX, 0, 1 = replace the thermometer code with the popcount-equivalent code

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous active-high reset
- pdb  in  1  power-down negate; 1 = operate
- supply_ok  in  1  supply monitor good (digital, already synchronised)
- datain  in  BIN_W  binary data, true rail
- datainb  in  BIN_W  binary data, complement rail
- datatherm  in  THERM_W  thermometer data, true rail
- datathermb  in  THERM_W  thermometer data, complement rail
- err_clr  in  1  clear all sticky flags
- databinout  out  BIN_W  retimed binary, true
- databinoutb  out  BIN_W  retimed binary, complement
- datathermout  out  THERM_W  retimed thermometer, true
- datathermoutb  out  THERM_W  retimed thermometer, complement
- out_en  out  1  switches driven, aligned with the outputs
- state  out  2  OFF=0, SETTLE=1, ACTIVE=2
- comp_err  out  1  sticky: true/complement rails not complementary
- therm_err  out  1  sticky: non-thermometer (bubble) code seen
- supply_fault  out  1  sticky: supply_ok lost while ACTIVE

## Operation
- Reset: state=OFF, settle counter=0, every pipeline register=0, all data outputs=0, out_en=0, all flags=0.
- FSM, evaluated on each rising edge; good = pdb & supply_ok:
  - OFF: if good, go to SETTLE with count=0. Otherwise stay.
  - SETTLE: if !good, go to OFF. Else if count==SETTLE_CYC-1, go to ACTIVE. Else increment count.
  - ACTIVE: if !supply_ok, go to OFF and set supply_fault. Else if !pdb, go to OFF. Otherwise stay.
- Data path:
  - Only the true rails datain/datatherm enter the pipeline.
  - Stage 0 is the input, after optional bubble fix. Stages 1..PIPE_DEPTH-1 load unconditionally.
  - The output register loads the tail stage when state==ACTIVE, and loads 0 otherwise.
  - Complement outputs are the bitwise NOT of the true output register when out_en=1, and 0 when out_en=0. Both rails 0 means all switches off, which replaces the old tri-state behaviour.
- out_en is a register: next = (state==ACTIVE).
- Bubble fix (BUBBLE_FIX=1): stage 0 thermometer = ((1<<popcount(datatherm))-1), with popcount in 0..THERM_W. BUBBLE_FIX=0 passes the code through unchanged.
- Error detection applies only in cycles where state==ACTIVE, and uses the raw inputs:
  - comp_err sets if any bit has datain==datainb or datatherm==datathermb.
  - therm_err sets if datatherm is not of the form 0…01…1, meaning contiguous ones from the LSB; all-0 and all-1 are legal. It is flagged regardless of BUBBLE_FIX.
- Flags are sticky and cleared by err_clr. When a set and err_clr occur in the same cycle, the set wins.

## Timing
- Data latency:
  - An input during cycle c appears on the outputs during cycle c+PIPE_DEPTH, provided state==ACTIVE in cycle c+PIPE_DEPTH-1.
  - Sticky flags assert the cycle after the offending input.
- Power-up: if pdb and supply_ok first go good in cycle c:
  - state=SETTLE in c+1 and ACTIVE in c+1+SETTLE_CYC.
  - out_en=1 and the first non-zero data appear in c+2+SETTLE_CYC.
  - Pipeline contents captured before ACTIVE may appear; they are not masked.
- Power-down or supply loss in cycle c: state=OFF in c+1. The outputs still carry valid data in c+1, and are 0 with out_en=0 from c+2.
- A good drop during SETTLE restarts the full settle on the next good. The count is not retained.
- rst mid-operation: all outputs are 0 in the cycle after the reset edge, regardless of state.

## Test plan
- Reset release with pdb=1, supply_ok=1, SETTLE_CYC=8 → out_en rises exactly 10 cycles after the first good cycle; state sequence 0,1×8,2.
- ACTIVE, PIPE_DEPTH=2, datain=7'h55 in cycle c → databinout=7'h55 and databinoutb=7'h2A in cycle c+2; changing datainb has no effect on the outputs.
- datatherm=17'h0000F in ACTIVE → no error. datatherm=17'h0000D → therm_err=1 next cycle. With BUBBLE_FIX=1, datathermout=17'h00007.
- datain=datainb=0 for one cycle in ACTIVE → comp_err=1 and stays set; err_clr asserted in the same cycle as a new violation → comp_err remains 1.
- supply_ok drops for 1 cycle while ACTIVE → supply_fault=1, outputs and out_en=0 two cycles later; full SETTLE repeats before data resumes.
- pdb toggled low mid-SETTLE after 5 cycles, then high → ACTIVE reached only after 8 fresh good cycles; rst asserted while ACTIVE → all outputs 0 the next cycle.
